// File: rtl/fmul_seq.sv
// fmul_seq: iterative IEEE-754 multiplier (shift-add, one mantissa bit per cycle,
// round-to-nearest-even). Operands in and product out over valid/ready handshakes.
// Optional feature macro: FMUL_SPECIAL_EN (NaN/Inf handling, overflow saturation,
// underflow flush). Without it, all-ones exponents are ordinary numbers and the
// exponent wraps modulo 2^EXP; zero operands still yield a signed zero.
module fmul_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int EXP = (N == 64) ? 11 : 8;
  localparam int MAN = (N == 64) ? 52 : 23;
  localparam int MW  = MAN + 1;
  localparam int PW  = 2 * MW;
  localparam int EW  = EXP + 2;
  localparam int CW  = $clog2(MW);

  localparam logic signed [EW-1:0] BIAS_S   = EW'(2 ** (EXP - 1) - 1);
  localparam logic signed [EW-1:0] ONE_S    = EW'(1);
  localparam logic        [CW-1:0] CNT_LAST = CW'(MAN);
`ifdef FMUL_SPECIAL_EN
  localparam logic signed [EW-1:0] EMAX_S   = EW'(2 ** EXP - 1);
  localparam logic signed [EW-1:0] ZERO_S   = '0;
  localparam logic        [N-1:0]  QNAN     = {1'b0, {EXP{1'b1}}, 1'b1, {(MAN-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t                 state;
  state_t                 state_nx;

  logic                   sign_p0;
  logic signed [EW-1:0]   exp_p0;
  logic [MW-1:0]          mcand_p0;
  logic [MW-1:0]          mplier_p0;
  logic [PW-1:0]          acc_p0;
  logic [CW-1:0]          cnt;

  logic [EXP-1:0]         ea;
  logic [EXP-1:0]         eb;
  logic [MAN-1:0]         fa;
  logic [MAN-1:0]         fb;
  logic                   sign_in;
  logic signed [EW-1:0]   exp_sum;
  logic                   spec_hit;
  logic [N-1:0]           spec_word;
  logic [MW:0]            upper_sum;
  logic [PW-1:0]          acc_step;

  // Final packing: saturate/flush when special handling is built in, else wrap.
  function automatic logic [N-1:0] saturate_pack(input logic s,
                                                 input logic signed [EW-1:0] e,
                                                 input logic [MAN-1:0] frac);
`ifdef FMUL_SPECIAL_EN
    if (e >= EMAX_S)
      return {s, {EXP{1'b1}}, {MAN{1'b0}}};
    else if (e <= ZERO_S)
      return {s, {(N-1){1'b0}}};
    else
      return {s, e[EXP-1:0], frac};
`else
    return {s, e[EXP-1:0], frac};
`endif
  endfunction

  // Normalise the raw product, round to nearest even and pack the result word.
  function automatic logic [N-1:0] round_pack(input logic s,
                                              input logic signed [EW-1:0] e_in,
                                              input logic [PW-1:0] p);
    logic [MAN-1:0]       mant;
    logic [MAN:0]         mant_r;
    logic                 guard;
    logic                 sticky;
    logic                 up;
    logic signed [EW-1:0] e;
    e = e_in;
    if (p[PW-1]) begin
      mant   = p[PW-2:MW];
      guard  = p[MAN];
      sticky = |p[MAN-1:0];
      e      = e + ONE_S;
    end else begin
      mant   = p[PW-3:MAN];
      guard  = p[MAN-1];
      sticky = |p[MAN-2:0];
    end
    up     = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {{MAN{1'b0}}, up};
    if (mant_r[MAN])
      e = e + ONE_S;
    return saturate_pack(s, e, mant_r[MAN-1:0]);
  endfunction

  assign ea      = a[N-2 -: EXP];
  assign eb      = b[N-2 -: EXP];
  assign fa      = a[MAN-1:0];
  assign fb      = b[MAN-1:0];
  assign sign_in = a[N-1] ^ b[N-1];
  assign exp_sum = signed'({2'b00, ea}) + signed'({2'b00, eb}) - BIAS_S;

  // Operands that bypass the multiplier loop and their immediate result word.
  always_comb begin
    spec_hit  = (ea == '0) || (eb == '0);
    spec_word = {sign_in, {(N-1){1'b0}}};
`ifdef FMUL_SPECIAL_EN
    if (((&ea) && (|fa)) || ((&eb) && (|fb))) begin
      spec_hit  = 1'b1;
      spec_word = QNAN;
    end else if (((&ea) && (eb == '0)) || ((&eb) && (ea == '0))) begin
      spec_hit  = 1'b1;
      spec_word = QNAN;
    end else if ((&ea) || (&eb)) begin
      spec_hit  = 1'b1;
      spec_word = {sign_in, {EXP{1'b1}}, {MAN{1'b0}}};
    end
`endif
  end

  // One shift-add step: add multiplicand into the upper half, then shift right.
  always_comb begin
    upper_sum = {1'b0, acc_p0[PW-1:MW]} + (mplier_p0[0] ? {1'b0, mcand_p0} : '0);
    acc_step  = {upper_sum, acc_p0[MW-1:1]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic; handshake inputs are only looked at in their own state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = spec_hit ? DONE : MUL;
      MUL:  if (cnt == CNT_LAST) state_nx = NORM;
      NORM: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Stage p0 boundary: operand capture at accept (no reset, data only).
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      sign_p0   <= sign_in;
      exp_p0    <= exp_sum;
      mcand_p0  <= {1'b1, fa};
      mplier_p0 <= {1'b1, fb};
    end else if (state == MUL) begin
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

  // Accumulator, bit counter and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_p0 <= '0;
      cnt    <= '0;
      out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc_p0 <= '0;
            cnt    <= '0;
            if (spec_hit)
              out <= spec_word;
          end
        end
        MUL: begin
          acc_p0 <= acc_step;
          cnt    <= cnt + CW'(1);
        end
        NORM:    out <= round_pack(sign_p0, exp_p0, acc_p0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_seq.sv
// Self-checking bench for fmul_seq (N=32): directed cases plus randomized
// operands against an arithmetic reference model of the IEEE product.
module tb_fmul_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;

  fmul_seq #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference product from the real-number rules: exact integer product,
  // round-half-to-even on the discarded remainder.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int              ex, ey, e, sh;
    logic            s;
    longint unsigned mx, my, p, q, rem, half;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
`ifdef FMUL_SPECIAL_EN
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return 32'h7FC00000;
    if ((ex == 255 && ey == 0) || (ey == 255 && ex == 0)) return 32'h7FC00000;
    if (ex == 255 || ey == 255) return {s, 8'hFF, 23'h0};
`endif
    if (ex == 0 || ey == 0) return {s, 31'h0};
    mx = {40'd0, 1'b1, x[22:0]};
    my = {40'd0, 1'b1, y[22:0]};
    p  = mx * my;
    e  = ex + ey - 127;
    if (p >= (64'd1 << 47)) begin sh = 24; e++; end
    else sh = 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
`ifdef FMUL_SPECIAL_EN
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
`endif
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int          sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel == 0)      r[30:23] = 8'h00;
    else if (sel == 1) r[30:23] = 8'hFF;
    else if (sel == 2) r = $urandom;
    else               r[30:23] = 8'($urandom_range(64, 190));
    return r;
  endfunction

  // Present one operand pair (in IDLE), wait boundedly for out_valid.
  // cyc = cycle index (1 = cycle right after the accept edge) where out_valid is seen.
  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      output logic [31:0] res, output int cyc, output logic busy_rdy);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    busy_rdy = 1'b0;
    while (!out_valid && cyc < 100) begin
      busy_rdy = busy_rdy | in_ready;
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) check("timeout", 32'd0, 32'd1);
    res = out;
  endtask

  task automatic drain();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] res, held, exp_w;
    logic        busy;
    int          cyc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out, 32'h0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1.5 x 2.0: latency and busy in_ready
    send(32'h3FC00000, 32'h40000000, res, cyc, busy);
    check("mul_1p5x2", res, 32'h40400000);
    check("lat_normal", cyc, 26);
    check("busy_in_ready", {31'd0, busy}, 32'd0);
    drain();
    check("rdy_after_hs", {31'd0, in_ready}, 32'd1);

    send(32'hC0000000, 32'h3F000000, res, cyc, busy);
    check("mul_neg", res, 32'hBF800000);
    drain();

    send(32'h80000000, 32'h3F800000, res, cyc, busy);
    check("mul_negzero", res, 32'h80000000);
    check("lat_zero", cyc, 1);
    drain();

    send(32'h3F800001, 32'h3F800001, res, cyc, busy);
    check("round_lsb", res, 32'h3F800002);
    drain();

    send(32'h3FFFFFFF, 32'h3FFFFFFF, res, cyc, busy);
    check("norm_msb", res, 32'h407FFFFE);
    drain();

    send(32'h7F000000, 32'h40800000, res, cyc, busy);
`ifdef FMUL_SPECIAL_EN
    check("ovf_big", res, 32'h7F800000);
`else
    check("ovf_wrap", res, 32'h00000000);
`endif
    drain();

    send(32'h7F800000, 32'h00000000, res, cyc, busy);
`ifdef FMUL_SPECIAL_EN
    check("inf_x_zero", res, 32'h7FC00000);
    check("lat_special", cyc, 1);
`else
    check("allones_x_zero", res, 32'h00000000);
`endif
    drain();

`ifdef FMUL_SPECIAL_EN
    send(32'h7F000000, 32'h40000000, res, cyc, busy);
    check("ovf_sat", res, 32'h7F800000);
    drain();
`endif

    // Backpressure: out held, new operands ignored
    out_ready = 1'b0;
    send(32'h3FC00000, 32'h40000000, held, cyc, busy);
    check("bp_value", held, 32'h40400000);
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_out_stable", out, held);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    check("bp_valid_held", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    check("bp_release_vld", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of MUL
    a = 32'h3FC00000; b = 32'h3FC00000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_vld", {31'd0, out_valid}, 32'd0);
    check("midrst_out", out, 32'h0);
    check("midrst_rdy", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h40000000, 32'h40000000, res, cyc, busy);
    check("post_rst", res, 32'h40800000);
    drain();

    // Randomized operands against the model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] x, y;
      x = rand_op();
      y = rand_op();
      exp_w = ref_mul(x, y);
      check("rnd_pre_rdy", {31'd0, in_ready}, 32'd1);
      send(x, y, res, cyc, busy);
      check($sformatf("rnd %h*%h", x, y), res, exp_w);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
